// File: rtl/wishbone_cmd_master.sv
// wishbone_cmd_master: single-transfer classic Wishbone master.
// Takes read/write commands on a valid/ready port, runs one CYC/STB cycle
// per command and returns read data and status on a valid/ready port.
// Optional ACK timeout: define WB_CMD_MASTER_TIMEOUT_EN to enable it.
module wishbone_cmd_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    // response port
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    // Wishbone master port
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state;

    // A zero timeout would abort every transfer before the slave can answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wishbone_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // BUS cycles elapsed without ACK; cleared when the transfer starts
    logic [CNT_W-1:0] wait_cnt;
`else
    // no timeout path exists, so a transfer can never fail
    assign rsp_err_o = 1'b0;
`endif

    // Transfer FSM: command accept, Wishbone cycle, response hand-off
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            adr_o       <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            dat_o       <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        adr_o       <= cmd_adr_i;
                        we_o        <= cmd_we_i;
                        dat_o       <= cmd_dat_i;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        cmd_ready_o <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                        state       <= BUS;
                    end
                end

                BUS: begin
                    // ACK is checked first so it beats a same-edge timeout
                    if (ack_i) begin
                        rsp_dat_o   <= we_o ? '0 : dat_i;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt    <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Bench for wishbone_cmd_master: hand-computed vector table, reset and
// timeout sequences, then randomized transfers against a memory model.
// Define WB_CMD_MASTER_TIMEOUT_EN for both bench and RTL to cover timeouts.
module tb_wishbone_cmd_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_adr_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic [AW-1:0] adr_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0;

    always #5 clk = ~clk;

    wishbone_cmd_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .adr_o      (adr_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .ack_i      (ack_i)
    );

    int vectors = 0;
    int miscompares = 0;

    // slave_mem is what the bench slave stores from the bus;
    // ref_mem is the expected contents derived from the command stream
    logic [DW-1:0] slave_mem [16];
    logic [DW-1:0] ref_mem   [16];
    logic          ack_stuck = 1'b0;

    typedef struct {
        logic          we;
        logic [3:0]    adr;
        logic [DW-1:0] dat;
        int            dly;
        int            hold;
        logic [DW-1:0] exp_dat;
        logic          exp_err;
        int            exp_cyc;
    } vec_t;

    vec_t vtab [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of one command from the transfer rules alone
    task automatic model(input logic we, input logic [3:0] adr, input logic [DW-1:0] dat,
                         input int dly, output logic [DW-1:0] e_dat,
                         output logic e_err, output int e_cyc);
        e_cyc = dly + 1;
        e_err = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        if (dly + 1 > TO) begin
            e_cyc = TO;
            e_err = 1'b1;
        end
`endif
        e_dat = (e_err || we) ? '0 : ref_mem[adr];
        if (we && !e_err) ref_mem[adr] = dat;
    endtask

    // One full transfer; called and returning at a falling edge
    task automatic run_txn(input logic we, input logic [3:0] adr, input logic [DW-1:0] dat,
                           input int dly, input int hold, input logic [DW-1:0] e_dat,
                           input logic e_err, input int e_cyc);
        int w;
        int k;
        w = 0;
        while (cmd_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = {28'h0, adr};
        cmd_dat_i   = dat;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("cyc_start", cyc_o, 1);
        check("stb_start", stb_o, 1);
        check("adr_o", adr_o, {28'h0, adr});
        check("we_o", we_o, we);
        check("dat_o", dat_o, dat);
        k = 0;
        while (cyc_o === 1'b1 && k < 64) begin
            k++;
            check("cmd_ready_bus", cmd_ready_o, 0);
            check("stb_bus", stb_o, 1);
            if (!ack_stuck) ack_i = (k == dly + 1);
            dat_i = slave_mem[adr_o[3:0]];
            if (ack_i && we_o) slave_mem[adr_o[3:0]] = dat_o;
            @(negedge clk);
        end
        if (!ack_stuck) ack_i = 1'b0;
        check("cyc_cycles", k, e_cyc);
        check("stb_end", stb_o, 0);
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_dat", rsp_dat_o, e_dat);
        check("rsp_err", rsp_err_o, e_err);
        // a second command waits while the response is pending
        cmd_valid_i = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rsp_valid_hold", rsp_valid_o, 1);
            check("rsp_dat_hold", rsp_dat_o, e_dat);
            check("cmd_ready_hold", cmd_ready_o, 0);
            check("cyc_hold", cyc_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        check("rsp_valid_done", rsp_valid_o, 0);
        check("cmd_ready_done", cmd_ready_o, 1);
        check("cyc_done", cyc_o, 0);
        check("adr_o_kept", adr_o, {28'h0, adr});
        check("dat_o_kept", dat_o, dat);
    endtask

    task automatic rand_txn(input int max_dly);
        logic          we;
        logic [3:0]    adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] e_dat;
        logic          e_err;
        int            dly;
        int            e_cyc;
        we  = 1'($urandom_range(0, 1));
        adr = 4'($urandom_range(0, 15));
        dat = $urandom;
        dly = ack_stuck ? 0 : $urandom_range(0, max_dly);
        model(we, adr, dat, dly, e_dat, e_err, e_cyc);
        run_txn(we, adr, dat, dly, $urandom_range(0, 3), e_dat, e_err, e_cyc);
    endtask

    initial begin
        logic [DW-1:0] m_dat;
        logic          m_err;
        int            m_cyc;

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end

        //          we    adr   dat           dly hold exp_dat       err   cyc
        vtab[0] = '{1'b1, 4'h2, 32'hDEADBEEF, 0,  0,   32'h00000000, 1'b0, 1};
        vtab[1] = '{1'b1, 4'h5, 32'h12345678, 1,  1,   32'h00000000, 1'b0, 2};
        vtab[2] = '{1'b0, 4'h5, 32'h00000000, 3,  0,   32'h12345678, 1'b0, 4};
        vtab[3] = '{1'b0, 4'h2, 32'hFFFFFFFF, 0,  5,   32'hDEADBEEF, 1'b0, 1};
        vtab[4] = '{1'b1, 4'h2, 32'hA5A50F0F, 2,  2,   32'h00000000, 1'b0, 3};
        vtab[5] = '{1'b0, 4'h2, 32'h00000000, 1,  0,   32'hA5A50F0F, 1'b0, 2};
        vtab[6] = '{1'b0, 4'h7, 32'h0BADF00D, 0,  1,   32'h00000000, 1'b0, 1};

        // reset values
        #12;
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_dat", rsp_dat_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_dat", dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // vector table
        for (int i = 0; i < 7; i++) begin
            model(vtab[i].we, vtab[i].adr, vtab[i].dat, vtab[i].dly, m_dat, m_err, m_cyc);
            run_txn(vtab[i].we, vtab[i].adr, vtab[i].dat, vtab[i].dly, vtab[i].hold,
                    vtab[i].exp_dat, vtab[i].exp_err, vtab[i].exp_cyc);
        end

        // reset while the cycle is open
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h9;
        cmd_dat_i   = 32'hCAFEF00D;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("rst_mid_cyc_before", cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", cyc_o, 0);
        check("rst_mid_stb", stb_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", cmd_ready_o, 1);
        check("rst_mid_rsp", rsp_valid_o, 0);
        @(negedge clk);
        check("rst_mid_rsp2", rsp_valid_o, 0);
        check("rst_mid_cyc2", cyc_o, 0);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // no ACK at all, then ACK on the expiry cycle, then a normal transfer
        model(1'b0, 4'h5, '0, 40, m_dat, m_err, m_cyc);
        run_txn(1'b0, 4'h5, '0, 40, 1, 32'h0, 1'b1, TO);
        model(1'b0, 4'h5, '0, TO - 1, m_dat, m_err, m_cyc);
        run_txn(1'b0, 4'h5, '0, TO - 1, 0, 32'h12345678, 1'b0, TO);
        model(1'b1, 4'h3, 32'h13579BDF, 0, m_dat, m_err, m_cyc);
        run_txn(1'b1, 4'h3, 32'h13579BDF, 0, 0, 32'h0, 1'b0, 1);
`endif

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rand_txn(20);
`else
            rand_txn(4);
`endif
        end
        // zero-wait slave: ACK held high throughout, including idle cycles
        ack_stuck = 1'b1;
        ack_i     = 1'b1;
        for (int i = 0; i < 10; i++) rand_txn(0);
        ack_stuck = 1'b0;
        ack_i     = 1'b0;
        for (int i = 0; i < 8; i++) rand_txn(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time bound
    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, got %0d vectors, expected end", vectors);
        $fatal(1, "time limit");
    end

endmodule
